load_store_unit: RTL and testbench
==================================

# load_store_unit

Sits between the single-cycle datapath (ALU result, register rt, control) and the word-only data memory. Adds sub-word accesses (LB/LBU/LH/LHU/SB/SH) on top of a memory that only reads and writes aligned 32-bit words. Loads are extracted and extended combinationally. Byte and halfword stores run as a two-cycle read-modify-write, and the unit stalls the PC for one cycle while the merge happens.

## Interface
Parameters:
- ADDR_W, 32, width of CPU and memory addresses

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- MemRead  in  1  CPU load request
- MemWrite  in  1  CPU store request
- MemSize  in  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved (treated as word)
- MemUnsigned  in  1  zero-extend loads when 1, sign-extend when 0
- adress  in  ADDR_W  byte address from the ALU
- storeData  in  32  store data; low byte or halfword is used for SB/SH
- loadData  out  32  extended load result to the writeback mux
- stall  out  1  hold the PC and pipeline-visible state this cycle
- misaligned  out  1  access is misaligned; see Configuration
- mem_MemRead  out  1  to data memory
- mem_MemWrite  out  1  to data memory
- mem_adress  out  ADDR_W  to data memory, with bits [1:0] forced to 00
- mem_writeData  out  32  to data memory
- mem_readData  in  32  word read from data memory (combinational)

## Operation
- States: IDLE, MERGE.
- Reset values: state IDLE, merge register 0.
- While reset is high, stall = 0, mem_MemWrite = 0, mem_MemRead = 0, loadData = 0 and misaligned = 0.
- Loads (MemRead=1, MemWrite=0):
  - mem_MemRead is 1 and there is no stall.
  - Byte lane is selected by adress[1:0]; lane 0 is bits [7:0], lane 3 is bits [31:24].
  - Halfword is selected by adress[1]; adress[1]=0 selects bits [15:0].
  - The result is zero- or sign-extended per MemUnsigned.
  - LW passes the word through unchanged.
- SW (IDLE, MemWrite=1, MemSize=10): mem_MemWrite=1 and mem_writeData=storeData in the same cycle. No stall.
- SB/SH while in IDLE:
  - mem_MemRead=1, mem_MemWrite=0, stall=1.
  - On the clock edge, the merge register captures mem_readData with the target lane replaced by storeData. State moves to MERGE.
- MERGE:
  - mem_MemWrite=1, mem_writeData=merge register, stall=0.
  - The CPU holds the same instruction across both cycles, so adress is the same.
  - Next state is IDLE unconditionally.
- MemRead and MemWrite both 1: the store takes precedence and loadData=0.
- Neither MemRead nor MemWrite: all memory strobes are 0 and loadData=0.
- Reset asserted during MERGE: return to IDLE and suppress the write. Memory is unchanged.

## Timing
- Loads, SW and idle cycles: zero added latency, fully combinational from the inputs to loadData and to the memory strobes.
- SB/SH: exactly 2 cycles.
  - Cycle 0: read and stall.
  - Cycle 1: memory write commits at the end of cycle 1; the PC advances at the same edge.
- stall is a combinational function of the state and the inputs. It is never high in MERGE.
- Back-to-back SB after SB: the second store sees IDLE after MERGE, so it reads the word already updated by the first.

## Configuration
- MISALIGN_TRAP_EN defined:
  - misaligned = 1 for a halfword with adress[0]≠0, or a word with adress[1:0]≠00.
  - On such accesses all memory strobes are forced to 0, stall=0 and loadData=0.
  - No MERGE entry.
- MISALIGN_TRAP_EN undefined:
  - misaligned is tied to 0.
  - The offending low bits are ignored: halfwords use adress[1] only, words use the aligned word.

## Structure
- Shared package mips_mem_pkg holds:
  - MemSize encodings: SIZE_BYTE, SIZE_HALF, SIZE_WORD.
  - The state enum (LSU_IDLE, LSU_MERGE).
- The lane extract/merge logic is pure combinational and lives in sub-module byte_lane_merge. It takes a word, adress[1:0], MemSize, MemUnsigned and storeData, and returns the extended load value and the merged store word.

## Test plan
- Memory word 0x80 = 0x8899AABB; LB at 0x83 → loadData=0xFFFFFF88. LBU at 0x83 → 0x00000088. LH at 0x80 → 0xFFFFAABB.
- SB storeData=0x11 at 0x81 over 0x8899AABB:
  - stall=1 for one cycle, then a single write of 0x889911BB.
  - Word reads back as 0x889911BB.
- SH 0x1234 at 0x42, immediately followed by SB 0x56 at 0x40 (word initially 0) → final word 0x12340056.
- SW 0xDEADBEEF at 0x10 → written in one cycle with no stall. LW at 0x10 returns 0xDEADBEEF.
- Reset pulsed in the MERGE cycle of an SB → word unchanged, state IDLE, stall=0.
- With MISALIGN_TRAP_EN: LW at 0x21 → misaligned=1, loadData=0, no write strobe. Without it: same LW returns word 0x20.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared encodings for the data-memory path: access sizes and load/store unit states.
package mips_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic {
        LSU_IDLE  = 1'b0,
        LSU_MERGE = 1'b1
    } lsu_state_e;

    // Byte and halfword need read-modify-write; word and the reserved code do not.
    function automatic logic is_subword(input logic [1:0] size);
        return !size[1];
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// CPU-side request/response and word-memory signals of the load/store unit.
interface load_store_unit_if #(
    parameter int ADDR_W = 32
) ();
    logic              MemRead;
    logic              MemWrite;
    logic [1:0]        MemSize;
    logic              MemUnsigned;
    logic [ADDR_W-1:0] adress;
    logic [31:0]       storeData;
    logic [31:0]       loadData;
    logic              stall;
    logic              misaligned;
    logic              mem_MemRead;
    logic              mem_MemWrite;
    logic [ADDR_W-1:0] mem_adress;
    logic [31:0]       mem_writeData;
    logic [31:0]       mem_readData;

    modport slave (
        input  MemRead, MemWrite, MemSize, MemUnsigned, adress, storeData, mem_readData,
        output loadData, stall, misaligned, mem_MemRead, mem_MemWrite, mem_adress, mem_writeData
    );

    modport master (
        output MemRead, MemWrite, MemSize, MemUnsigned, adress, storeData, mem_readData,
        input  loadData, stall, misaligned, mem_MemRead, mem_MemWrite, mem_adress, mem_writeData
    );
endinterface

// File: rtl/byte_lane_merge.sv
// Pure combinational lane logic: extracts/extends sub-word loads and splices
// sub-word store data into a read word.
module byte_lane_merge
    import mips_mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_store,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte   = i_word[{i_off, 3'b000} +: 8];
        w_half   = i_off[1] ? i_word[31:16] : i_word[15:0];
        o_load   = i_word;
        o_merged = i_store;
        case (i_size)
            SIZE_BYTE: begin
                o_load   = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
                o_merged = i_word;
                o_merged[{i_off, 3'b000} +: 8] = i_store[7:0];
            end
            SIZE_HALF: begin
                // Halfword lane uses bit 1 only; bit 0 is either trapped or ignored upstream.
                o_load   = {{16{w_half[15] & ~i_unsigned}}, w_half};
                o_merged = i_off[1] ? {i_store[15:0], i_word[15:0]}
                                    : {i_word[31:16], i_store[15:0]};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: sub-word loads on a word-only memory, and two-cycle RMW for SB/SH.
// Optional misalignment trap enabled by defining MISALIGN_TRAP_EN.
module load_store_unit
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    load_store_unit_if.slave  bus
);
    lsu_state_e  r_state;
    lsu_state_e  w_next;
    logic [31:0] r_merge;
    logic [31:0] w_load;
    logic [31:0] w_merged;
    logic        w_mis;
    logic        w_sub;

    byte_lane_merge u_lane (
        .i_word     (bus.mem_readData),
        .i_off      (bus.adress[1:0]),
        .i_size     (bus.MemSize),
        .i_unsigned (bus.MemUnsigned),
        .i_store    (bus.storeData),
        .o_load     (w_load),
        .o_merged   (w_merged)
    );

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        w_mis = 1'b0;
        if (!reset && (bus.MemRead || bus.MemWrite)) begin
            if (bus.MemSize == SIZE_HALF)
                w_mis = bus.adress[0];
            else if (bus.MemSize[1])
                w_mis = |bus.adress[1:0];
        end
    end
`else
    assign w_mis = 1'b0;
`endif

    assign w_sub          = bus.MemWrite && is_subword(bus.MemSize) && !w_mis;
    assign bus.misaligned = w_mis;
    assign bus.mem_adress = {bus.adress[ADDR_W-1:2], 2'b00};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= LSU_IDLE;
            r_merge <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == LSU_IDLE && w_sub)
                r_merge <= w_merged;
        end
    end

    always_comb begin
        w_next            = LSU_IDLE;
        bus.stall         = 1'b0;
        bus.mem_MemRead   = 1'b0;
        bus.mem_MemWrite  = 1'b0;
        bus.mem_writeData = '0;
        bus.loadData      = '0;
        // Reset held high also blanks the MERGE write, so an interrupted RMW leaves memory intact.
        if (!reset) begin
            case (r_state)
                LSU_IDLE: begin
                    if (w_mis) begin
                        w_next = LSU_IDLE;
                    end else if (bus.MemWrite) begin
                        if (w_sub) begin
                            bus.mem_MemRead = 1'b1;
                            bus.stall       = 1'b1;
                            w_next          = LSU_MERGE;
                        end else begin
                            bus.mem_MemWrite  = 1'b1;
                            bus.mem_writeData = bus.storeData;
                        end
                    end else if (bus.MemRead) begin
                        bus.mem_MemRead = 1'b1;
                        bus.loadData    = w_load;
                    end
                end
                LSU_MERGE: begin
                    bus.mem_MemWrite  = 1'b1;
                    bus.mem_writeData = r_merge;
                    w_next            = LSU_IDLE;
                end
                default: w_next = LSU_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word memory model, table-driven loads, hand-written
// RMW/reset sequences and randomized traffic against a shift/mask reference model.
module tb_load_store_unit;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   wr_cnt = 0;

    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = '0;
    logic [31:0] pl_data = '0;

    load_store_unit_if #(.ADDR_W(32)) bus ();

    load_store_unit #(.ADDR_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    assign bus.mem_readData = mem[bus.mem_adress[7:2]];

    always @(posedge clock) begin
        if (pl_en)
            mem[pl_idx] <= pl_data;
        else if (bus.mem_MemWrite) begin
            mem[bus.mem_adress[7:2]] <= bus.mem_writeData;
            wr_cnt <= wr_cnt + 1;
        end
    end

    typedef struct {
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [10];

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [1:0] sz, input logic u);
        int sh;
        logic [31:0] v;
        v = w;
        if (sz == 2'b00) begin
            sh = 8 * int'(a[1:0]);
            v = (w >> sh) & 32'hFF;
            if (!u && v[7]) v = v | 32'hFFFFFF00;
        end else if (sz == 2'b01) begin
            sh = 16 * int'(a[1]);
            v = (w >> sh) & 32'hFFFF;
            if (!u && v[15]) v = v | 32'hFFFF0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [31:0] a,
                                              input logic [1:0] sz, input logic [31:0] d);
        int sh;
        logic [31:0] m;
        if (sz == 2'b00) begin
            sh = 8 * int'(a[1:0]);
            m  = 32'hFF << sh;
            return (w & ~m) | ((d & 32'hFF) << sh);
        end else if (sz == 2'b01) begin
            sh = 16 * int'(a[1]);
            m  = 32'hFFFF << sh;
            return (w & ~m) | ((d & 32'hFFFF) << sh);
        end
        return d;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.MemRead = 1'b0; bus.MemWrite = 1'b0; bus.MemSize = 2'b10;
        bus.MemUnsigned = 1'b0; bus.adress = '0; bus.storeData = '0;
    endtask

    // Called and returns at posedge+1.
    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        pl_en = 1'b1; pl_idx = a[7:2]; pl_data = v;
        ref_mem[a[7:2]] = v;
        @(posedge clock); #1;
        pl_en = 1'b0;
    endtask

    // One CPU access, starting and ending at posedge+1, with all strobes checked.
    task automatic do_access(input logic rd, input logic wr, input logic [1:0] sz, input logic u,
                             input logic [31:0] a, input logic [31:0] d, output logic [31:0] ld);
        logic mis, sub, strobe_w;
        logic [31:0] w, exp_ld;
        int wc0;
        mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
        if (rd || wr) mis = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
`endif
        sub      = wr && !sz[1] && !mis;
        strobe_w = wr && !sub && !mis;
        w        = ref_mem[a[7:2]];
        exp_ld   = (rd && !wr && !mis) ? ref_load(w, a, sz, u) : 32'h0;
        wc0      = wr_cnt;
        bus.MemRead = rd; bus.MemWrite = wr; bus.MemSize = sz;
        bus.MemUnsigned = u; bus.adress = a; bus.storeData = d;
        @(negedge clock);
        chk("stall", {31'b0, bus.stall}, {31'b0, sub});
        chk("mem_rd", {31'b0, bus.mem_MemRead}, {31'b0, !mis && (sub || (rd && !wr))});
        chk("mem_wr", {31'b0, bus.mem_MemWrite}, {31'b0, strobe_w});
        chk("load", bus.loadData, exp_ld);
        chk("misaligned", {31'b0, bus.misaligned}, {31'b0, mis});
        chk("mem_adr", bus.mem_adress, a & 32'hFFFF_FFFC);
        if (strobe_w) chk("wdata", bus.mem_writeData, d);
        ld = bus.loadData;
        if (sub) begin
            @(posedge clock); #1;
            @(negedge clock);
            chk("merge_stall", {31'b0, bus.stall}, 32'h0);
            chk("merge_wr", {31'b0, bus.mem_MemWrite}, 32'h1);
            chk("merge_rd", {31'b0, bus.mem_MemRead}, 32'h0);
            chk("merge_wdata", bus.mem_writeData, ref_store(w, a, sz, d));
        end
        @(posedge clock); #1;
        idle_inputs();
        chk("write_count", wr_cnt - wc0, (wr && !mis) ? 32'd1 : 32'd0);
        if (wr && !mis) ref_mem[a[7:2]] = ref_store(w, a, sz, d);
    endtask

    logic [31:0] ld;

    initial begin
        idle_inputs();
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;

        // Reset with a pending SB and a load presented: everything must stay quiet.
        bus.MemWrite = 1'b1; bus.MemSize = 2'b00; bus.adress = 32'h81; bus.MemRead = 1'b1;
        @(negedge clock);
        chk("rst_stall", {31'b0, bus.stall}, 32'h0);
        chk("rst_mem_wr", {31'b0, bus.mem_MemWrite}, 32'h0);
        chk("rst_mem_rd", {31'b0, bus.mem_MemRead}, 32'h0);
        chk("rst_load", bus.loadData, 32'h0);
        chk("rst_mis", {31'b0, bus.misaligned}, 32'h0);
        idle_inputs();
        @(posedge clock); #1;
        for (int i = 0; i < 64; i++) preload(32'(i * 4), $urandom);
        reset = 1'b0;

        // Table-driven loads from word 0x80.
        preload(32'h80, 32'h8899AABB);
        vt[0] = '{2'b00, 1'b0, 32'h83, 32'hFFFFFF88};
        vt[1] = '{2'b00, 1'b1, 32'h83, 32'h00000088};
        vt[2] = '{2'b01, 1'b0, 32'h80, 32'hFFFFAABB};
        vt[3] = '{2'b01, 1'b1, 32'h82, 32'h00008899};
        vt[4] = '{2'b00, 1'b0, 32'h80, 32'hFFFFFFBB};
        vt[5] = '{2'b00, 1'b1, 32'h81, 32'h000000AA};
        vt[6] = '{2'b00, 1'b0, 32'h82, 32'hFFFFFF99};
        vt[7] = '{2'b01, 1'b0, 32'h82, 32'hFFFF8899};
        vt[8] = '{2'b10, 1'b0, 32'h80, 32'h8899AABB};
        vt[9] = '{2'b11, 1'b1, 32'h80, 32'h8899AABB};
        for (int i = 0; i < 10; i++) begin
            do_access(1'b1, 1'b0, vt[i].sz, vt[i].uns, vt[i].addr, 32'h0, ld);
            chk($sformatf("table%0d", i), ld, vt[i].exp);
        end

        // SB 0x11 at 0x81, then read back.
        do_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h81, 32'h11, ld);
        chk("sb_mem", mem[32], 32'h889911BB);
        do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h80, 32'h0, ld);
        chk("sb_readback", ld, 32'h889911BB);

        // SH then SB back-to-back into the same word.
        preload(32'h40, 32'h0);
        do_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h42, 32'hFFFF1234, ld);
        do_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h40, 32'hABCDEF56, ld);
        chk("sh_sb_word", mem[16], 32'h12340056);

        // SW and LW, then simultaneous read+write, then no request.
        do_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, ld);
        do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, ld);
        chk("lw_after_sw", ld, 32'hDEADBEEF);
        do_access(1'b1, 1'b1, 2'b10, 1'b0, 32'h14, 32'h0BADF00D, ld);
        chk("rdwr_load", ld, 32'h0);
        chk("rdwr_mem", mem[5], 32'h0BADF00D);
        do_access(1'b0, 1'b0, 2'b00, 1'b0, 32'h14, 32'h0, ld);

        // Reset pulsed during MERGE of an SB: write suppressed, back to IDLE.
        begin
            int wc0;
            preload(32'h80, 32'h8899AABB);
            wc0 = wr_cnt;
            bus.MemWrite = 1'b1; bus.MemSize = 2'b00; bus.adress = 32'h81; bus.storeData = 32'h11;
            @(negedge clock);
            chk("rm_stall0", {31'b0, bus.stall}, 32'h1);
            @(posedge clock); #1;
            reset = 1'b1;
            @(negedge clock);
            chk("rm_wr_blocked", {31'b0, bus.mem_MemWrite}, 32'h0);
            chk("rm_stall1", {31'b0, bus.stall}, 32'h0);
            @(posedge clock); #1;
            reset = 1'b0;
            idle_inputs();
            @(negedge clock);
            chk("rm_idle_wr", {31'b0, bus.mem_MemWrite}, 32'h0);
            chk("rm_idle_stall", {31'b0, bus.stall}, 32'h0);
            chk("rm_word", mem[32], 32'h8899AABB);
            chk("rm_wcount", wr_cnt - wc0, 32'h0);
            @(posedge clock); #1;
            do_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h81, 32'h11, ld);
        end

        // Misaligned word load.
        preload(32'h20, 32'hCAFEF00D);
        do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h21, 32'h0, ld);
`ifdef MISALIGN_TRAP_EN
        chk("lw_mis_load", ld, 32'h0);
`else
        chk("lw_mis_load", ld, 32'hCAFEF00D);
`endif

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            int op;
            logic r, w;
            op = int'($urandom_range(0, 9));
            r = (op < 4) || (op == 8);
            w = (op >= 4 && op < 9);
            do_access(r, w, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      32'($urandom_range(0, 255)), $urandom, ld);
        end
        for (int i = 0; i < 64; i++)
            chk($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
